accumulate_seq: RTL and testbench

// - Parametrised, mode-selectable accumulator driven by a loadable down-counter.
// - Sums exactly N accepted samples, then reports completion through a start/busy/done handshake.
// - Adds stall-able input (in_valid), add/subtract/saturate modes and a sticky overflow flag.
// - Used by the board demos: switches feed data, LEDs show the sum.

---
 rtl/accumulate_seq_pkg.sv | 16 +
 rtl/accumulate_seq_if.sv | 32 +++
 rtl/accumulate_seq_down_counter.sv | 27 ++
 rtl/accumulate_seq.sv | 116 +++++++++++
 tb/tb_accumulate_seq.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accumulate_seq_pkg.sv
// Shared types for the sample accumulator: arithmetic modes and controller states.
package accum_pkg;

  typedef enum logic [1:0] {
    ACC_ADD = 2'd0,
    ACC_SUB = 2'd1,
    ACC_SAT = 2'd2
  } acc_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/accumulate_seq_if.sv
// Control, sample and result signals of the accumulator, plus the controller state for observation.
interface accumulate_seq_if #(
  parameter int DATA_W = 5,
  parameter int CNT_W  = 5,
  parameter int SUM_W  = 10
);
  import accum_pkg::*;

  // Handshake: start is taken only while state is IDLE. In RUN, busy acts as ready and
  // a sample is accepted on every posedge where in_valid=1; there is no backpressure.
  logic              start;
  logic [CNT_W-1:0]  count_in;
  acc_mode_t         mode;
  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic [SUM_W-1:0]  sum;
  logic              busy;
  logic              done;
  logic              overflow;
  acc_state_t        state;

  modport master (
    output start, count_in, mode, data_in, in_valid,
    input  sum, busy, done, overflow, state
  );

  modport slave (
    input  start, count_in, mode, data_in, in_valid,
    output sum, busy, done, overflow, state
  );

endinterface

// File: rtl/accumulate_seq_down_counter.sv
// Loadable down-counter that tracks how many samples are still owed in the current run.
module down_counter #(
  parameter int W = 5
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero
);

  assign zero = (q == '0);

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en && !zero) begin
      q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/accumulate_seq.sv
// Run controller and datapath: sums exactly count_in accepted samples in the latched mode,
// then pulses done for one cycle.
module accumulate_seq
  import accum_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int CNT_W  = 5,
  parameter int SUM_W  = 10
) (
  input logic              Clock,
  input logic              Resetn,
  accumulate_seq_if.slave  bus
);

  if (SUM_W < DATA_W) begin : g_width_check
    $error("accumulate_seq: SUM_W must be at least DATA_W");
  end

  acc_state_t       state_q, state_d;
  acc_mode_t        mode_q;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_zero;
  logic             start_acc;
  logic             take;
  logic [SUM_W:0]   x_ext;
  logic [SUM_W:0]   add_w;
  logic [SUM_W:0]   sub_w;

  assign start_acc = (state_q == S_IDLE) && bus.start;
  assign take      = (state_q == S_RUN) && bus.in_valid;

  down_counter #(.W(CNT_W)) u_count (
    .Clock  (Clock),
    .Resetn (Resetn),
    .load   (start_acc),
    .en     (take),
    .d      (bus.count_in),
    .q      (cnt_q),
    .zero   (cnt_zero)
  );

  // One extra bit on the adder/subtractor exposes carry-out and borrow directly.
  assign x_ext = {{(SUM_W + 1 - DATA_W){1'b0}}, bus.data_in};
  assign add_w = {1'b0, sum_q} + x_ext;
  assign sub_w = {1'b0, sum_q} - x_ext;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.count_in != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // cnt_zero cannot be seen in RUN normally; it only guards against a stuck run.
        if (cnt_zero || (bus.in_valid && (cnt_q == CNT_W'(1)))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (start_acc) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end else if (take) begin
      case (mode_q)
        ACC_SUB: begin
          sum_d = sub_w[SUM_W-1:0];
          if (sub_w[SUM_W]) ovf_d = 1'b1;
        end
        ACC_SAT: begin
          if (add_w[SUM_W]) begin
            sum_d = '1;
            ovf_d = 1'b1;
          end else begin
            sum_d = add_w[SUM_W-1:0];
          end
        end
        default: begin
          sum_d = add_w[SUM_W-1:0];
          if (add_w[SUM_W]) ovf_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      mode_q  <= ACC_ADD;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      if (start_acc) mode_q <= bus.mode;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.overflow = ovf_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_accumulate_seq.sv
// Bench for accumulate_seq: a default-width instance and a narrow-sum instance share stimulus,
// both checked against an arithmetic model of the run.
`timescale 1ns/1ps
module tb_accumulate_seq;
  import accum_pkg::*;

  localparam int DATA_W  = 5;
  localparam int CNT_W   = 5;
  localparam int SUM_W   = 10;
  localparam int SUM_W_B = 8;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  accumulate_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W))   bus_a ();
  accumulate_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W_B)) bus_b ();

  assign bus_b.start    = bus_a.start;
  assign bus_b.count_in = bus_a.count_in;
  assign bus_b.mode     = bus_a.mode;
  assign bus_b.data_in  = bus_a.data_in;
  assign bus_b.in_valid = bus_a.in_valid;

  accumulate_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut_a (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_a)
  );

  accumulate_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W_B)) dut_b (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [SUM_W-1:0]   exp_q[$];
  logic [SUM_W_B-1:0] exp_qb[$];
  bit                 stim_v[$];
  logic [DATA_W-1:0]  stim_d[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers: m is the mode code, w the sum width.
  function automatic void model_step(input int s, input int m, input int x, input int w,
                                     output int ns, output bit ov);
    int lim;
    lim = 1 << w;
    ov  = 1'b0;
    case (m)
      1: begin
        ns = s - x;
        if (ns < 0) begin ns = ns + lim; ov = 1'b1; end
      end
      2: begin
        ns = s + x;
        if (ns > lim - 1) begin ns = lim - 1; ov = 1'b1; end
      end
      default: begin
        ns = s + x;
        if (ns >= lim) begin ns = ns - lim; ov = 1'b1; end
      end
    endcase
  endfunction

  task automatic push_s(input bit v, input int d);
    stim_v.push_back(v);
    stim_d.push_back(DATA_W'(d));
  endtask

  task automatic clear_stim();
    stim_v.delete();
    stim_d.delete();
  endtask

  task automatic random_stim(input int n, input int stall_pct);
    int k;
    bit v;
    clear_stim();
    k = 0;
    while (k < n) begin
      v = ($urandom_range(0, 99) >= stall_pct);
      push_s(v, $urandom_range(0, 31));
      if (v) k++;
    end
  endtask

  // One complete run: start, feed the stim queues, check every cycle, DONE and return to IDLE.
  task automatic do_run(input int n, input int m);
    int sa, sb, acc, idx, need, busy_seen;
    bit oa, ob, fa, fb, t;
    bit v;
    logic [DATA_W-1:0] d;

    sa = 0; sb = 0; acc = 0; need = 0; fa = 0; fb = 0;
    for (int i = 0; i < stim_v.size() && acc < n; i++) begin
      need++;
      if (stim_v[i]) begin
        model_step(sa, m, int'(stim_d[i]), SUM_W, sa, t);   fa |= t;
        model_step(sb, m, int'(stim_d[i]), SUM_W_B, sb, t); fb |= t;
        acc++;
      end
    end
    exp_q.push_back(SUM_W'(sa));
    exp_qb.push_back(SUM_W_B'(sb));

    bus_a.start    = 1'b1;
    bus_a.count_in = CNT_W'(n);
    bus_a.mode     = acc_mode_t'(m[1:0]);
    @(posedge Clock); #1;
    bus_a.start = 1'b0;
    check_eq("sum_clear_a", bus_a.sum, 0);
    check_eq("ovf_clear_a", bus_a.overflow, 0);
    check_eq("ovf_clear_b", bus_b.overflow, 0);

    sa = 0; sb = 0; oa = 0; ob = 0; acc = 0; idx = 0; busy_seen = 0;
    while (acc < n && idx < 200) begin
      check_eq("done_low_run", bus_a.done, 0);
      check_eq("busy_b_run", bus_b.busy, 1);
      busy_seen += int'(bus_a.busy);
      v = (idx < stim_v.size()) ? stim_v[idx] : 1'b0;
      d = (idx < stim_d.size()) ? stim_d[idx] : '0;
      bus_a.in_valid = v;
      bus_a.data_in  = d;
      @(posedge Clock); #1;
      if (v) begin
        model_step(sa, m, int'(d), SUM_W, sa, t);   oa |= t;
        model_step(sb, m, int'(d), SUM_W_B, sb, t); ob |= t;
        acc++;
      end
      check_eq("sum_run_a", bus_a.sum, sa);
      check_eq("sum_run_b", bus_b.sum, sb);
      check_eq("ovf_run_a", bus_a.overflow, oa);
      check_eq("ovf_run_b", bus_b.overflow, ob);
      idx++;
    end

    // Inputs outside RUN are don't-care, so scramble them.
    bus_a.in_valid = 1'($urandom_range(0, 1));
    bus_a.data_in  = DATA_W'($urandom_range(0, 31));
    check_eq("run_cycles", busy_seen, need);
    check_eq("done_high_a", bus_a.done, 1);
    check_eq("done_high_b", bus_b.done, 1);
    check_eq("busy_low_done", bus_a.busy, 0);
    check_eq("state_done", bus_a.state, S_DONE);
    check_eq("sum_done_a", bus_a.sum, exp_q.pop_front());
    check_eq("sum_done_b", bus_b.sum, exp_qb.pop_front());
    check_eq("ovf_done_a", bus_a.overflow, fa);
    check_eq("ovf_done_b", bus_b.overflow, fb);

    @(posedge Clock); #1;
    bus_a.in_valid = 1'b0;
    check_eq("done_pulse_a", bus_a.done, 0);
    check_eq("state_idle", bus_a.state, S_IDLE);
    check_eq("sum_hold_a", bus_a.sum, sa);
    check_eq("ovf_hold_b", bus_b.overflow, ob);
  endtask

  initial begin
    bus_a.start    = 1'b0;
    bus_a.count_in = '0;
    bus_a.mode     = ACC_ADD;
    bus_a.data_in  = '0;
    bus_a.in_valid = 1'b0;

    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_eq("rst_state", bus_a.state, S_IDLE);
    check_eq("rst_sum", bus_a.sum, 0);
    check_eq("rst_busy", bus_a.busy, 0);
    check_eq("rst_done", bus_a.done, 0);
    check_eq("rst_ovf", bus_a.overflow, 0);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    // ADD, back-to-back samples
    clear_stim();
    push_s(1, 5); push_s(1, 7); push_s(1, 9);
    do_run(3, 0);

    // ADD with stalls; stall-cycle data must be ignored
    clear_stim();
    push_s(1, 31); push_s(0, 3); push_s(0, 17); push_s(1, 31);
    push_s(1, 31); push_s(0, 9); push_s(1, 31);
    do_run(4, 0);

    // SUB below zero, then an ADD run clears the sticky flag
    clear_stim();
    push_s(1, 3); push_s(1, 1);
    do_run(2, 1);
    clear_stim();
    push_s(1, 2);
    do_run(1, 0);

    // Overflow left set in IDLE is cleared by reset
    clear_stim();
    push_s(1, 1);
    do_run(1, 1);
    check_eq("ovf_sticky_idle", bus_a.overflow, 1);
    Resetn = 1'b0;
    @(posedge Clock); #1;
    check_eq("rst_idle_ovf", bus_a.overflow, 0);
    check_eq("rst_idle_sum", bus_a.sum, 0);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    // Full-length runs in SAT and ADD; the narrow instance clamps / wraps
    clear_stim();
    for (int i = 0; i < 31; i++) push_s(1, 31);
    do_run(31, 2);
    do_run(31, 0);
    do_run(31, 3);

    // Zero-length run with start held through DONE
    bus_a.start    = 1'b1;
    bus_a.count_in = '0;
    bus_a.mode     = ACC_ADD;
    @(posedge Clock); #1;
    check_eq("zero_done", bus_a.done, 1);
    check_eq("zero_busy", bus_a.busy, 0);
    check_eq("zero_sum", bus_a.sum, 0);
    @(posedge Clock); #1;
    check_eq("held_start_idle", bus_a.state, S_IDLE);
    check_eq("held_start_done", bus_a.done, 0);
    @(posedge Clock); #1;
    check_eq("restart_from_idle", bus_a.state, S_DONE);
    bus_a.start = 1'b0;
    @(posedge Clock); #1;
    check_eq("zero_back_idle", bus_a.state, S_IDLE);

    // Reset in the middle of a run
    bus_a.start    = 1'b1;
    bus_a.count_in = CNT_W'(10);
    bus_a.mode     = ACC_ADD;
    @(posedge Clock); #1;
    bus_a.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.data_in  = DATA_W'(8);
      @(posedge Clock); #1;
    end
    check_eq("mid_sum", bus_a.sum, 40);
    check_eq("mid_busy", bus_a.busy, 1);
    Resetn = 1'b0;
    @(posedge Clock); #1;
    check_eq("mid_rst_state", bus_a.state, S_IDLE);
    check_eq("mid_rst_sum", bus_a.sum, 0);
    check_eq("mid_rst_busy", bus_a.busy, 0);
    check_eq("mid_rst_ovf", bus_a.overflow, 0);
    check_eq("mid_rst_done", bus_a.done, 0);
    Resetn = 1'b1;
    bus_a.in_valid = 1'b0;
    @(posedge Clock); #1;
    check_eq("mid_rst_no_done", bus_a.done, 0);
    check_eq("mid_rst_stay_idle", bus_a.state, S_IDLE);

    // Randomized runs over length, mode, stall density and data
    for (int r = 0; r < 30; r++) begin
      int n;
      int m;
      n = $urandom_range(0, 31);
      m = $urandom_range(0, 3);
      random_stim(n, $urandom_range(0, 60));
      do_run(n, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
